// File: rtl/video_stream_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_stream_source: AXI4-Stream video frame generator (SOF on tuser,|
// | EOL on tlast) with counter, LFSR and solid-colour patterns.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module video_stream_source #(
  parameter int DATA_WIDTH = 64,
  parameter int DIM_WIDTH  = 12,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic                  sw_reset,
  input  logic                  enable,
  input  logic [DIM_WIDTH-1:0]  cfg_width,
  input  logic [DIM_WIDTH-1:0]  cfg_height,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [1:0]            cfg_pattern,
  input  logic [DATA_WIDTH-1:0] cfg_color,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  localparam logic [31:0]          LFSR_SEED = 32'h0000_0001;
  localparam logic [31:0]          LFSR_TAPS = 32'h8020_0003;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE   = 1;
  localparam logic [GAP_WIDTH-1:0] GAP_ONE   = 1;

  logic [1:0]            state, state_next;
  logic [DIM_WIDTH-1:0]  x, y, w, h;
  logic [GAP_WIDTH-1:0]  gap, gap_cnt;
  logic [1:0]            pattern;
  logic [DATA_WIDTH-1:0] color;
  logic [31:0]           lfsr, lfsr_next;
  logic [15:0]           frames;
  logic                  done_pend;
  logic                  start_ok, accept, eol, eof, load;

  assign start_ok  = enable && (cfg_width != '0) && (cfg_height != '0);
  assign accept    = aclken && m_axis_video_tvalid && m_axis_video_tready;
  assign eol       = (x == w - DIM_ONE);
  assign eof       = eol && (y == h - DIM_ONE);
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  // Configuration is captured whenever the FSM is about to present a SOF beat.
  assign load      = (state_next == ACTIVE) && ((state != ACTIVE) || (accept && eof));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else if (aclken) begin
      state <= sw_reset ? IDLE : state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start_ok) state_next = ACTIVE;
      ACTIVE: if (accept && eof) begin
                if (!enable)          state_next = IDLE;
                else if (gap != '0)   state_next = GAP;
                else if (start_ok)    state_next = ACTIVE;
                else                  state_next = IDLE;
              end
      GAP:    if (gap_cnt == GAP_ONE) state_next = start_ok ? ACTIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x <= '0; y <= '0; w <= '0; h <= '0;
      gap <= '0; gap_cnt <= '0; pattern <= '0; color <= '0;
      lfsr <= LFSR_SEED; frames <= '0; done_pend <= 1'b0;
    end else if (aclken) begin
      done_pend <= 1'b0;
      if (sw_reset) begin
        x <= '0; y <= '0; w <= '0; h <= '0;
        gap <= '0; gap_cnt <= '0; pattern <= '0; color <= '0;
        lfsr <= LFSR_SEED; frames <= '0;
      end else begin
        if (load) begin
          w <= cfg_width; h <= cfg_height; gap <= cfg_gap;
          pattern <= cfg_pattern; color <= cfg_color;
          x <= '0; y <= '0; lfsr <= LFSR_SEED;
        end else if (accept) begin
          lfsr <= lfsr_next;
          if (eol) begin
            x <= '0;
            y <= eof ? '0 : y + DIM_ONE;
          end else begin
            x <= x + DIM_ONE;
          end
        end
        if (accept && eof) begin
          done_pend <= 1'b1;
          frames    <= frames + 16'd1;
          gap_cnt   <= gap;
        end else if (state == GAP) begin
          gap_cnt <= gap_cnt - GAP_ONE;
        end
      end
    end
  end

  // A pending done is shown only in a cycle where the clock enable is high.
  assign frame_done  = done_pend && aclken;
  assign frame_count = frames;

  always_comb begin
    m_axis_video_tvalid = (state == ACTIVE);
    m_axis_video_tuser  = m_axis_video_tvalid && (x == '0) && (y == '0);
    m_axis_video_tlast  = m_axis_video_tvalid && eol;
    busy                = (state != IDLE);
    m_axis_video_tdata  = '0;
    if (m_axis_video_tvalid) begin
      case (pattern)
        2'd1:    m_axis_video_tdata = {lfsr, ~lfsr};
        2'd2:    m_axis_video_tdata = color;
        default: m_axis_video_tdata = {frames, 16'(y), 16'(x), 16'hC0DE};
      endcase
    end
  end

endmodule
`default_nettype wire
